memory_bus_arbiter: RTL and testbench

Two-master arbiter that shares the SoC's single-port memory bus between the CPU (master 0) and a secondary bus master such as a UART loader or debug DMA (master 1). It sits between the masters and the memory/peripheral slave inside `Risco_5_SOC`. It grants one transaction at a time, forwards the request, returns the slave response to the owning master, and aborts transactions with a bus error when the slave stalls.

---
 rtl/memory_bus_arbiter_pkg.sv | 16 +
 rtl/memory_bus_arbiter_if.sv | 36 +++
 rtl/memory_bus_arbiter_bus_watchdog.sv | 38 +++
 rtl/memory_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Round-robin arbitration is enabled by MEMORY_BUS_ARBITER_ROUND_ROBIN_EN.
package memory_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// One request/response link of the memory bus.
// The master side issues requests; the slave side answers them.
interface memory_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import memory_bus_arbiter_pkg::*;

  logic          read_request;
  logic          write_request;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          response;
  logic          error;

  modport master (
    output read_request,
    output write_request,
    output address,
    output write_data,
    input  read_data,
    input  response
  );

  modport slave (
    input  read_request,
    input  write_request,
    input  address,
    input  write_data,
    output read_data,
    output response,
    output error
  );

endinterface

// File: rtl/memory_bus_arbiter_bus_watchdog.sv
// Saturating BUSY-cycle counter for the arbiter.
// expired flags the cycle whose increment reaches TIMEOUT_CYCLES.
module bus_watchdog
  import memory_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (r_count != LIMIT) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  assign expired = enable && (w_count_nxt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master memory bus arbiter with slave-stall timeout.
// Define MEMORY_BUS_ARBITER_ROUND_ROBIN_EN for round-robin contention.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  memory_bus_arbiter_if.slave  m0,
  memory_bus_arbiter_if.slave  m1,
  memory_bus_arbiter_if.master s
);

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_owner;
  logic                  r_s_rd;
  logic                  r_s_wr;
  logic [ADDR_WIDTH-1:0] r_s_addr;
  logic [DATA_WIDTH-1:0] r_s_wdata;
  logic [DATA_WIDTH-1:0] r_rdata [2];
  logic [1:0]            r_resp;
  logic [1:0]            r_err;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_sel;
  logic                  w_grant;
  logic                  w_done_ok;
  logic                  w_timeout;
  logic                  w_busy;
  logic                  w_expired;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_req0 = m0.read_request | m0.write_request;
  assign w_req1 = m1.read_request | m1.write_request;
  assign w_busy = (r_state == BUSY);

`ifdef MEMORY_BUS_ARBITER_ROUND_ROBIN_EN
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= OWNER_M1;
    end else if (w_grant) begin
      r_last_grant <= w_sel;
    end
  end

  assign w_sel = (w_req0 && w_req1) ? ~r_last_grant
               : (w_req0 ? OWNER_M0 : OWNER_M1);
`else
  assign w_sel = w_req0 ? OWNER_M0 : OWNER_M1;
`endif

  always_comb begin
    w_sel_rd    = m0.read_request;
    w_sel_wr    = m0.write_request;
    w_sel_addr  = m0.address;
    w_sel_wdata = m0.write_data;
    if (w_sel == OWNER_M1) begin
      w_sel_rd    = m1.read_request;
      w_sel_wr    = m1.write_request;
      w_sel_addr  = m1.address;
      w_sel_wdata = m1.write_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req0 || w_req1) begin
          w_grant     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // a response in the expiry cycle still counts as success
        if (s.response) begin
          w_done_ok   = 1'b1;
          w_state_nxt = DONE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OWNER_M0;
      r_s_rd     <= 1'b0;
      r_s_wr     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_resp     <= '0;
      r_err      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_resp  <= '0;
      r_err   <= '0;
      if (w_grant) begin
        r_owner   <= w_sel;
        r_s_wr    <= w_sel_wr;
        r_s_rd    <= w_sel_rd & ~w_sel_wr;
        r_s_addr  <= w_sel_addr;
        r_s_wdata <= w_sel_wdata;
      end
      if (w_done_ok || w_timeout) begin
        r_s_rd           <= 1'b0;
        r_s_wr           <= 1'b0;
        r_resp[r_owner]  <= 1'b1;
        r_err[r_owner]   <= w_timeout;
        r_rdata[r_owner] <= w_done_ok ? s.read_data : '0;
      end
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_grant),
    .enable (w_busy),
    .expired(w_expired)
  );

  assign s.read_request  = r_s_rd;
  assign s.write_request = r_s_wr;
  assign s.address       = r_s_addr;
  assign s.write_data    = r_s_wdata;

  assign m0.read_data = r_rdata[0];
  assign m0.response  = r_resp[0];
  assign m0.error     = r_err[0];
  assign m1.read_data = r_rdata[1];
  assign m1.response  = r_resp[1];
  assign m1.error     = r_err[1];

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter with TIMEOUT_CYCLES = 8.
// Honors MEMORY_BUS_ARBITER_ROUND_ROBIN_EN for the contention order.
module tb_memory_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  memory_bus_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  memory_bus_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  memory_bus_arbiter_if #(.AW(32), .DW(32)) s_if ();

  memory_bus_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if)
  );

  typedef struct {
    logic        m;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] sdata;
    logic        exp_wr;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd_model [2];
  vec_t        vecs [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic m, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      m1_if.read_request  = rd;
      m1_if.write_request = wr;
      m1_if.address       = a;
      m1_if.write_data    = d;
    end else begin
      m0_if.read_request  = rd;
      m0_if.write_request = wr;
      m0_if.address       = a;
      m0_if.write_data    = d;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic own_resp;
    logic oth_resp;
    logic own_err;
    logic [31:0] own_rd;
    logic [31:0] oth_rd;
    bit got;
    int c;
    @(negedge clk);
    set_req(v.m, v.rd, v.wr, v.addr, v.wdata);
    got = 0;
    c = 0;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      own_resp = v.m ? m1_if.response  : m0_if.response;
      own_err  = v.m ? m1_if.error     : m0_if.error;
      own_rd   = v.m ? m1_if.read_data : m0_if.read_data;
      oth_resp = v.m ? m0_if.response  : m1_if.response;
      oth_rd   = v.m ? m0_if.read_data : m1_if.read_data;
      chk($sformatf("v%0d_other_resp", idx), 32'(oth_resp), 32'd0);
      if (c == 1) begin
        chk($sformatf("v%0d_s_addr", idx), s_if.address, v.addr);
        chk($sformatf("v%0d_s_wdata", idx), s_if.write_data, v.wdata);
      end
      if (own_resp === 1'b1) begin
        got = 1;
        chk($sformatf("v%0d_resp_cycle", idx), c, v.exp_cyc);
        chk($sformatf("v%0d_rdata", idx), own_rd, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), 32'(own_err), 32'(v.exp_err));
        chk($sformatf("v%0d_s_req_done", idx),
            32'({s_if.read_request, s_if.write_request}), 32'd0);
        chk($sformatf("v%0d_other_rdata", idx), oth_rd, rd_model[!v.m]);
        rd_model[v.m] = v.exp_rdata;
        set_req(v.m, 1'b0, 1'b0, 32'd0, 32'd0);
        s_if.response = 1'b0;
      end else begin
        chk($sformatf("v%0d_s_req", idx),
            32'({s_if.read_request, s_if.write_request}),
            32'({~v.exp_wr, v.exp_wr}));
        s_if.response  = (c == v.lat);
        s_if.read_data = v.sdata;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d_no_response: got none expected one by cycle %0d",
               idx, v.exp_cyc);
      set_req(v.m, 1'b0, 1'b0, 32'd0, 32'd0);
      s_if.response = 1'b0;
    end
  endtask

  task automatic contend(input string tag, input logic exp_first,
                         input logic exp_second);
    logic first_o;
    logic second_o;
    int n;
    first_o  = 1'bx;
    second_o = 1'bx;
    n = 0;
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 32'h500, 32'h1111);
    set_req(1'b1, 1'b0, 1'b1, 32'h600, 32'h2222);
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (m0_if.response === 1'b1) begin
        if (n == 0) first_o = 1'b0; else second_o = 1'b0;
        n++;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      if (m1_if.response === 1'b1) begin
        if (n == 0) first_o = 1'b1; else second_o = 1'b1;
        n++;
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      s_if.response  = s_if.read_request | s_if.write_request;
      s_if.read_data = 32'd0;
    end
    s_if.response = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk({tag, "_served"}, n, 2);
    chk({tag, "_first"}, 32'(first_o), 32'(exp_first));
    chk({tag, "_second"}, 32'(second_o), 32'(exp_second));
    rd_model[0] = 32'd0;
    rd_model[1] = 32'd0;
  endtask

  initial begin
    logic rr_first;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    s_if.response  = 1'b0;
    s_if.read_data = 32'd0;
    s_if.error     = 1'b0;
    rd_model[0] = 32'd0;
    rd_model[1] = 32'd0;

    //       m     rd    wr    addr        wdata         lat sdata
    //       exp_wr cyc rdata         err
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hCAFEBABE,
                1'b0, 2, 32'hCAFEBABE, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h200, 32'h11223344, 3, 32'h0,
                1'b1, 4, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h12345678,
                1'b0, 9, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 8, 32'h5A5A5A5A,
                1'b0, 9, 32'h5A5A5A5A, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 2, 32'h0,
                1'b1, 3, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 5, 32'h0BADF00D,
                1'b0, 6, 32'h0BADF00D, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 0, 32'h77777777,
                1'b0, 9, 32'h0, 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_s_req", 32'({s_if.read_request, s_if.write_request}), 32'd0);
    chk("rst_s_addr", s_if.address, 32'd0);
    chk("rst_m_resp", 32'({m0_if.response, m1_if.response}), 32'd0);
    chk("rst_m_err", 32'({m0_if.error, m1_if.error}), 32'd0);
    chk("rst_m0_rdata", m0_if.read_data, 32'd0);

    contend("pairA", 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

`ifdef MEMORY_BUS_ARBITER_ROUND_ROBIN_EN
    rr_first = 1'b1;
`else
    rr_first = 1'b0;
`endif
    contend("pairB", rr_first, ~rr_first);

    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 32'h700, 32'h77);
    repeat (2) @(negedge clk);
    chk("mid_s_wr", 32'(s_if.write_request), 32'd1);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_s_req",
        32'({s_if.read_request, s_if.write_request}), 32'd0);
    chk("mid_rst_s_addr", s_if.address, 32'd0);
    chk("mid_rst_s_wdata", s_if.write_data, 32'd0);
    s_if.response  = 1'b1;
    s_if.read_data = 32'hFFFFFFFF;
    @(negedge clk);
    s_if.response = 1'b0;
    chk("late_resp_a", 32'({m0_if.response, m1_if.response}), 32'd0);
    @(negedge clk);
    chk("late_resp_b", 32'({m0_if.response, m1_if.response}), 32'd0);
    chk("late_m0_rdata", m0_if.read_data, 32'd0);

    contend("pairR", 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
